// File: rtl/bus_protocol_if.sv
// Generic single-word bus between the AHB bridge and its peripherals.
// The peripheral drives the read data, the error flag and the stall.
interface bus_protocol_if;
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic [31:0] rdata;
    logic        error;
    logic        request_stall;

    modport peripheral_vital (
        input  wen, ren, addr, wdata, strobe,
        output rdata, error, request_stall
    );

    modport protocol (
        output wen, ren, addr, wdata, strobe,
        input  rdata, error, request_stall
    );
endinterface

// File: rtl/vortex_mem_host_initiator.sv
// Host-side initiator that turns single 32-bit bus accesses into 512-bit Vortex line requests.
// The bus is stalled for the whole request/response round trip.
module vortex_mem_host_initiator #(
    parameter logic [31:0] MEM_BASE_ADDR  = 32'h8000_0000,
    parameter int          WINDOW_BITS    = 15,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          TAG_WIDTH      = 10
) (
    input  logic                 clk,
    input  logic                 nRST,
    output logic                 mem_req_valid,
    output logic                 mem_req_rw,
    output logic [63:0]          mem_req_byteen,
    output logic [25:0]          mem_req_addr,
    output logic [511:0]         mem_req_data,
    output logic [TAG_WIDTH-1:0] mem_req_tag,
    input  logic                 mem_req_ready,
    input  logic                 mem_rsp_valid,
    input  logic [511:0]         mem_rsp_data,
    input  logic [TAG_WIDTH-1:0] mem_rsp_tag,
    output logic                 mem_rsp_ready,
    bus_protocol_if.peripheral_vital bpif
);

    localparam int          CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] WIN_MASK = (32'd1 << WINDOW_BITS) - 32'd1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       seq_q;
    logic [3:0]       lane_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic [31:0]      rdata_q;

    logic             req_in, in_window, start, rsp_hit, timeout;
    logic [25:0]      line_addr;

    assign req_in    = bpif.wen | bpif.ren;
    assign in_window = (bpif.addr & ~WIN_MASK) == 32'd0;
    assign start     = (state_q == IDLE) && req_in && in_window;
    assign line_addr = 26'((MEM_BASE_ADDR + (bpif.addr & WIN_MASK)) >> 6);
    assign rsp_hit   = mem_rsp_valid && (mem_rsp_tag == mem_req_tag);
    assign timeout   = (cnt_q == CNT_MAX);

    assign mem_rsp_ready = 1'b1;
    assign bpif.rdata    = rdata_q;

    // NOTE: async reset in the sensitivity list; state updates use non-blocking assignments.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d            = state_q;
        bpif.request_stall = 1'b0;
        bpif.error         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_in) begin
                    if (in_window) begin
                        bpif.request_stall = 1'b1;
                        state_d            = REQ;
                    end else begin
                        bpif.error = 1'b1;
                    end
                end
            end
            REQ: begin
                bpif.request_stall = 1'b1;
                if (mem_req_valid && mem_req_ready) state_d = mem_req_rw ? DONE : WAIT_RSP;
            end
            WAIT_RSP: begin
                bpif.request_stall = 1'b1;
                if (rsp_hit || timeout) state_d = DONE;
            end
            DONE: begin
                bpif.error = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            mem_req_valid  <= 1'b0;
            mem_req_rw     <= 1'b0;
            mem_req_byteen <= '0;
            mem_req_addr   <= '0;
            mem_req_data   <= '0;
            mem_req_tag    <= '0;
            seq_q          <= '0;
            lane_q         <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            rdata_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        // Write wins when both strobes are raised together.
                        mem_req_valid  <= 1'b1;
                        mem_req_rw     <= bpif.wen;
                        mem_req_addr   <= line_addr;
                        mem_req_data   <= {16{bpif.wdata}};
                        mem_req_byteen <= bpif.wen ? ({60'b0, bpif.strobe} << {bpif.addr[5:2], 2'b00})
                                                   : {64{1'b1}};
                        mem_req_tag    <= TAG_WIDTH'(seq_q);
                        lane_q         <= bpif.addr[5:2];
                    end
                end
                REQ: begin
                    if (mem_req_valid && mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        seq_q         <= seq_q + 8'd1;
                        cnt_q         <= '0;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_hit) begin
                        rdata_q <= mem_rsp_data[{lane_q, 5'b0} +: 32];
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE:    err_q <= 1'b0;
                default: err_q <= 1'b0;
            endcase
        end
    end

endmodule
